// File: rtl/fb_writer_if.sv
// Handshake bundle between the color buffer, fb_writer and frame-buffer memory.
// The slave modport is the writer's view; master is the surrounding system.
interface fb_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int X_WIDTH    = 8,
  parameter int Y_WIDTH    = 7
);
  logic                  start;
  logic                  abort;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_rts;
  logic                  in_rtr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  mem_ack;
  logic                  busy;
  logic                  frame_done;
  logic [X_WIDTH-1:0]    cur_x;
  logic [Y_WIDTH-1:0]    cur_y;

  modport slave (
    input  start, abort, in_data, in_rts, mem_ack,
    output in_rtr, mem_addr, mem_wdata, mem_we, busy, frame_done, cur_x, cur_y
  );

  modport master (
    output start, abort, in_data, in_rts, mem_ack,
    input  in_rtr, mem_addr, mem_wdata, mem_we, busy, frame_done, cur_x, cur_y
  );
endinterface

// File: rtl/fb_writer.sv
// Frame-buffer write controller: pops color words and writes them in raster
// order, one acknowledged memory write per pixel, H_RES x V_RES per start.
module fb_writer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    H_RES      = 160,
  parameter int                    V_RES      = 120,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    X_WIDTH    = 8,
  parameter int                    Y_WIDTH    = 7
) (
  input  logic        clk,
  input  logic        rst_,
  fb_writer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                r_state;
  state_e                w_next;
  logic [X_WIDTH-1:0]    r_x;
  logic [Y_WIDTH-1:0]    r_y;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic w_in_rtr;
  logic w_mem_we;
  logic w_busy;
  logic w_frame_done;
  logic w_xfc;
  logic w_ack;
  logic w_last_x;
  logic w_last_y;

  // in_rtr is a pure decode of RECV, so the transfer needs only in_rts there.
  assign w_xfc    = (r_state == S_RECV)  && bus.in_rts;
  assign w_ack    = (r_state == S_WRITE) && bus.mem_ack;
  assign w_last_x = (r_x == X_WIDTH'(H_RES - 1));
  assign w_last_y = (r_y == Y_WIDTH'(V_RES - 1));

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    if (bus.abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.start) w_next = S_RECV;
        S_RECV:  if (w_xfc)     w_next = S_WRITE;
        S_WRITE: if (w_ack)     w_next = (w_last_x && w_last_y) ? S_DONE : S_RECV;
        S_DONE:                 w_next = S_IDLE;
        default:                w_next = S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    w_in_rtr     = 1'b0;
    w_mem_we     = 1'b0;
    w_busy       = 1'b1;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE:  w_busy       = 1'b0;
      S_RECV:  w_in_rtr     = 1'b1;
      S_WRITE: w_mem_we     = 1'b1;
      S_DONE:  w_frame_done = 1'b1;
      default: w_busy       = 1'b0;
    endcase
  end

  // Pixel counters, address and write data; abort freezes all of them.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_x     <= '0;
      r_y     <= '0;
      r_addr  <= BASE_ADDR;
      r_wdata <= '0;
    end else if (!bus.abort) begin
      if ((r_state == S_IDLE) && bus.start) begin
        r_x    <= '0;
        r_y    <= '0;
        r_addr <= BASE_ADDR;
      end
      if (w_xfc) begin
        r_wdata <= bus.in_data;
      end
      if (w_ack && !(w_last_x && w_last_y)) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        if (w_last_x) begin
          r_x <= '0;
          r_y <= r_y + Y_WIDTH'(1);
        end else begin
          r_x <= r_x + X_WIDTH'(1);
        end
      end
    end
  end

  assign bus.in_rtr     = w_in_rtr;
  assign bus.mem_we     = w_mem_we;
  assign bus.busy       = w_busy;
  assign bus.frame_done = w_frame_done;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.cur_x      = r_x;
  assign bus.cur_y      = r_y;

endmodule

// File: tb/tb_fb_writer.sv
// Bench for fb_writer: a transaction-level model checks every cycle, plus
// directed scenarios with hand-computed timing and address expectations.
module tb_fb_writer;

  localparam int          H    = 4;
  localparam int          V    = 2;
  localparam int          NPIX = H * V;
  localparam logic [15:0] BASE = 16'h0100;

  logic clk  = 1'b0;
  logic rst_ = 1'b0;

  always #5 clk = ~clk;

  fb_writer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .X_WIDTH(8), .Y_WIDTH(7)) bus  ();
  fb_writer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .X_WIDTH(8), .Y_WIDTH(7)) bus2 ();

  fb_writer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .H_RES(H), .V_RES(V),
    .BASE_ADDR(BASE), .X_WIDTH(8), .Y_WIDTH(7)
  ) u_dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  fb_writer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .H_RES(4), .V_RES(1),
    .BASE_ADDR(16'hFFFE), .X_WIDTH(8), .Y_WIDTH(7)
  ) u_wrap (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Stimulus knobs
  bit rand_rts  = 1'b0;
  int stall_pix = -1;
  int stall_len = 0;
  int stall_cnt = 0;

  // Upstream FIFO and memory responder: act just after each rising edge.
  always @(posedge clk) begin
    int pix;
    #1;
    pix = 32'(bus.cur_y) * H + 32'(bus.cur_x);
    bus.in_rts  = rand_rts ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.in_data = 32'hA0 + 32'(pix);
    if (!bus.mem_we) begin
      stall_cnt   = 0;
      bus.mem_ack = 1'b1;
    end else if (pix == stall_pix && stall_cnt < stall_len) begin
      stall_cnt++;
      bus.mem_ack = 1'b0;
    end else begin
      bus.mem_ack = 1'b1;
    end
  end

  // Behavioural model: a frame is a sequence of pixel indices; each index
  // needs one popped word then one acknowledged write at BASE + index.
  bit          m_busy  = 1'b0;
  bit          m_done  = 1'b0;
  bit          m_have  = 1'b0;
  int          m_idx   = 0;
  logic [31:0] m_word  = '0;
  int          m_writes = 0;
  int          stall_we = 0;

  always @(negedge clk) begin
    if (!rst_) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_have = 1'b0;
      m_idx  = 0;
    end else begin
      check("busy",       32'(bus.busy),       32'(m_busy));
      check("frame_done", 32'(bus.frame_done), 32'(m_done));
      check("in_rtr",     32'(bus.in_rtr),     32'(m_busy && !m_done && !m_have));
      check("mem_we",     32'(bus.mem_we),     32'(m_busy && !m_done && m_have));
      check("mem_addr",   32'(bus.mem_addr),   32'((32'(BASE) + m_idx) & 32'hFFFF));
      check("cur_x",      32'(bus.cur_x),      32'(m_idx % H));
      check("cur_y",      32'(bus.cur_y),      32'(m_idx / H));
      if (m_have) check("mem_wdata", bus.mem_wdata, m_word);
      if (bus.mem_we && bus.mem_addr == 16'h0102) stall_we++;

      if (bus.abort) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        m_have = 1'b0;
      end else if (m_done) begin
        m_done = 1'b0;
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (bus.start) begin
          m_busy   = 1'b1;
          m_idx    = 0;
          m_have   = 1'b0;
          m_writes = 0;
        end
      end else if (!m_have) begin
        if (bus.in_rts) begin
          m_have = 1'b1;
          m_word = bus.in_data;
        end
      end else if (bus.mem_ack) begin
        m_have = 1'b0;
        m_writes++;
        if (m_idx == NPIX - 1) m_done = 1'b1;
        else                   m_idx++;
      end
    end
  end

  // One frame on the main DUT; start may be re-pulsed after `poke` cycles.
  task automatic run_frame(input int poke, input int budget, output int cycles);
    @(posedge clk); #1;
    bus.start = 1'b1;
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (bus.frame_done) break;
      if (cycles >= budget) begin
        check("frame_timeout", 32'(cycles), 32'(budget + 1));
        break;
      end
      @(posedge clk); #1;
      bus.start = (poke != 0 && cycles == poke);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  initial begin
    int          cycles;
    int          found;
    int          nw;
    logic [15:0] waddr [4];

    bus.start = 1'b0;  bus.abort = 1'b0;
    bus.in_rts = 1'b0; bus.in_data = '0; bus.mem_ack = 1'b0;
    bus2.start = 1'b0; bus2.abort = 1'b0;
    bus2.in_rts = 1'b1; bus2.in_data = '0; bus2.mem_ack = 1'b1;

    #12;
    check("rst_busy",   32'(bus.busy),       32'd0);
    check("rst_rtr",    32'(bus.in_rtr),     32'd0);
    check("rst_we",     32'(bus.mem_we),     32'd0);
    check("rst_done",   32'(bus.frame_done), 32'd0);
    check("rst_addr",   32'(bus.mem_addr),   32'h0100);
    check("rst_wdata",  bus.mem_wdata,       32'd0);
    check("rst_x",      32'(bus.cur_x),      32'd0);
    check("rst_y",      32'(bus.cur_y),      32'd0);
    @(posedge clk); #1;
    rst_ = 1'b1;

    // Full-speed frame: 2 cycles per pixel plus start and DONE.
    run_frame(0, 60, cycles);
    check("t1_cycles", 32'(cycles),   32'd18);
    check("t1_writes", 32'(m_writes), 32'd8);
    @(negedge clk);
    check("t1_done_1cyc", 32'(bus.frame_done), 32'd0);
    check("t1_idle",      32'(bus.busy),       32'd0);

    // Pixel 2 acknowledged only on its fourth WRITE cycle.
    stall_pix = 2; stall_len = 3; stall_we = 0;
    run_frame(0, 60, cycles);
    check("t2_cycles",   32'(cycles),   32'd21);
    check("t2_held",     32'(stall_we), 32'd4);
    check("t2_writes",   32'(m_writes), 32'd8);
    stall_pix = -1;

    // Randomly gapped upstream data.
    rand_rts = 1'b1;
    run_frame(0, 300, cycles);
    check("t3_writes", 32'(m_writes), 32'd8);
    rand_rts = 1'b0;

    // Address wrap on a 4x1 frame at 0xFFFE.
    @(posedge clk); #1;
    bus2.start = 1'b1;
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus2.mem_we && bus2.mem_ack && nw < 4) begin
        waddr[nw] = bus2.mem_addr;
        bus2.in_data = 32'(nw);
        nw++;
      end
      if (bus2.frame_done) break;
      @(posedge clk); #1;
      bus2.start = 1'b0;
    end
    bus2.start = 1'b0;
    check("t4_nwrites", 32'(nw), 32'd4);
    check("t4_addr0", 32'(waddr[0]), 32'hFFFE);
    check("t4_addr1", 32'(waddr[1]), 32'hFFFF);
    check("t4_addr2", 32'(waddr[2]), 32'h0000);
    check("t4_addr3", 32'(waddr[3]), 32'h0001);

    // Abort during the WRITE of pixel 5 (x=1, y=1) while ack is also high.
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_we && bus.cur_x == 8'd1 && bus.cur_y == 7'd1) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("t5_reach", 32'(found), 32'd1);
    bus.abort = 1'b1;
    @(posedge clk); #1; bus.abort = 1'b0;
    @(negedge clk);
    check("t5_busy", 32'(bus.busy),   32'd0);
    check("t5_we",   32'(bus.mem_we), 32'd0);
    check("t5_rtr",  32'(bus.in_rtr), 32'd0);
    check("t5_x",    32'(bus.cur_x),  32'd1);
    check("t5_y",    32'(bus.cur_y),  32'd1);
    repeat (4) begin
      @(negedge clk);
      check("t5_no_done", 32'(bus.frame_done), 32'd0);
    end
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(negedge clk);
    check("t5_restart_rtr",  32'(bus.in_rtr),   32'd1);
    check("t5_restart_addr", 32'(bus.mem_addr), 32'h0100);
    check("t5_restart_x",    32'(bus.cur_x),    32'd0);
    check("t5_restart_y",    32'(bus.cur_y),    32'd0);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.frame_done) begin
        found = 1;
        break;
      end
    end
    check("t5_complete", 32'(found), 32'd1);

    // start pulsed mid-frame must not disturb the frame.
    run_frame(5, 60, cycles);
    check("t6_cycles", 32'(cycles),   32'd18);
    check("t6_writes", 32'(m_writes), 32'd8);

    // Asynchronous reset in the middle of a frame.
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_ = 1'b0;
    #1;
    check("t7_busy",  32'(bus.busy),       32'd0);
    check("t7_rtr",   32'(bus.in_rtr),     32'd0);
    check("t7_we",    32'(bus.mem_we),     32'd0);
    check("t7_done",  32'(bus.frame_done), 32'd0);
    check("t7_addr",  32'(bus.mem_addr),   32'h0100);
    check("t7_wdata", bus.mem_wdata,       32'd0);
    check("t7_x",     32'(bus.cur_x),      32'd0);
    check("t7_y",     32'(bus.cur_y),      32'd0);
    @(posedge clk); #1; rst_ = 1'b1;

    // start presented during the DONE cycle is ignored.
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.frame_done) begin
        found = 1;
        break;
      end
    end
    check("t8_reach_done", 32'(found), 32'd1);
    bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t8_stay_idle", 32'(bus.busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_writer.md
# fb_writer

Frame-buffer write controller sitting directly downstream of the color buffer FIFO. It pops 32-bit color words over the rts/rtr handshake and writes them to frame-buffer memory in raster order (x fastest, then y), one memory write per pixel with a ready/ack handshake. One `start` pulse writes exactly H_RES×V_RES pixels, then signals completion.

## Interface
- DATA_WIDTH, 32, color word width (matches color buffer output).
- ADDR_WIDTH, 16, frame-buffer word-address width.
- H_RES, 160, pixels per line.
- V_RES, 120, lines per frame.
- BASE_ADDR, 0, address of pixel (0,0).
- X_WIDTH, 8 / Y_WIDTH, 7, counter widths; must hold H_RES-1 / V_RES-1.

- clk  in  1  clock; all state changes on rising edge.
- rst_  in  1  reset, asynchronous, active-low.
- start  in  1  begin a frame; sampled only in IDLE.
- abort  in  1  synchronous frame abort; highest priority after reset.
- in_data  in  DATA_WIDTH  color word from the color buffer.
- in_rts  in  1  color buffer has data.
- in_rtr  out  1  fb_writer accepts in_data this cycle.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_we  out  1  write request; held until acked.
- mem_ack  in  1  memory accepted the write this cycle.
- busy  out  1  high in any state but IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel is acked.
- cur_x  out  X_WIDTH  column of the pixel being fetched/written.
- cur_y  out  Y_WIDTH  row of the pixel being fetched/written.

## Operation
- States: IDLE, RECV, WRITE, DONE. All outputs are Moore (decoded from registered state and registers), with no combinational path from inputs.
- Reset (async): state=IDLE; cur_x=0, cur_y=0, mem_addr=BASE_ADDR, mem_wdata=0; in_rtr=0, mem_we=0, busy=0, frame_done=0.
- IDLE: in_rtr=0, mem_we=0. If start=1, clear cur_x/cur_y, set mem_addr=BASE_ADDR, and go to RECV.
- RECV: in_rtr=1. On in_xfc = in_rts & in_rtr, latch in_data into mem_wdata and go to WRITE. Otherwise stay in RECV.
- WRITE: mem_we=1, in_rtr=0. mem_addr and mem_wdata are stable until ack. When mem_ack=1:
  - Last pixel (cur_x==H_RES-1 and cur_y==V_RES-1): go to DONE; counters hold.
  - End of line (cur_x==H_RES-1): cur_x=0, cur_y+1, mem_addr+1, go to RECV.
  - Otherwise: cur_x+1, mem_addr+1, go to RECV.
- DONE: frame_done=1 for exactly this one cycle, then go to IDLE.
- Address arithmetic: mem_addr increments by 1 per acked pixel, modulo 2^ADDR_WIDTH, so it wraps silently. The address for (x,y) equals BASE_ADDR + y·H_RES + x (mod 2^ADDR_WIDTH).
- abort=1 in any state: next state is IDLE, mem_we and in_rtr drop next cycle, no frame_done pulse, and counters hold their values. A word already latched but not acked is discarded. abort beats start and mem_ack in the same cycle.
- start while busy is ignored. start in the same cycle as DONE is ignored; it is accepted the following cycle in IDLE.
- mem_ack outside WRITE is ignored.
- in_rts with in_rtr=0 is not a transfer; the word stays in the upstream FIFO.

## Timing
- Start to first in_rtr: 1 cycle (start sampled at edge N, RECV from edge N).
- Minimum pixel period: 2 cycles (1 RECV + 1 WRITE with same-cycle ack). Frame minimum is 2·H_RES·V_RES + 2 cycles from start to frame_done.
- A word popped at edge N drives mem_we/mem_wdata from edge N. mem_ack at edge M moves the FSM to RECV at M, so in_rtr is high in cycle M.
- Last ack at edge M puts frame_done high in cycle M to M+1, and busy low from edge M+1.
- Async reset mid-frame takes effect immediately, with no memory write and no frame_done.

## Test plan
- H_RES=4, V_RES=2, BASE_ADDR=0x0100, in_rts always 1, mem_ack always 1, push 0xA0..0xA7 -> 8 writes to 0x0100..0x0107 with data 0xA0..0xA7, frame_done 1 cycle, start to frame_done = 18 cycles.
- Same frame with mem_ack delayed 3 cycles on pixel 2 -> mem_we/mem_addr=0x0102/mem_wdata=0xA2 held 4 cycles, in_rtr=0 throughout, no extra pops.
- in_rts toggled randomly -> in_rtr stays high in RECV, pixels are still written in order, and cur_x/cur_y wrap 3→0 with y 0→1.
- BASE_ADDR=0xFFFE, 4×1 frame -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- abort in WRITE of pixel 5 -> IDLE next cycle, no frame_done. A new start restarts at BASE_ADDR with cur_x=cur_y=0.
- Each of these, run separately:
  - start pulsed while busy -> ignored.
  - rst_ low mid-frame -> all outputs at reset values asynchronously.
  - start in the DONE cycle -> no new frame.
